cla_result_collector: RTL and testbench

- Downstream stage of the 8-bit carry-lookahead adder.
- Consumes one adder result byte (sum plus carry-out) per handshake and returns the chained carry to the adder as its carry-in for the next byte, so a wide addition runs LSB-first as a byte sequence.
- Buffers NBYTES result bytes, then streams them out byte-serially with valid/ready, plus a final carry flag.

---
 rtl/cla_pkg.sv | 19 +
 rtl/cla_result_collector.sv | 129 ++++++++++++
 tb/tb_cla_result_collector.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types and constants for the carry-lookahead adder slice.
// The adder datapath width is fixed; NBYTES_DEFAULT is the default number
// of bytes per wide addition handled by the result collector.
package cla_pkg;

  localparam int W              = 8;
  localparam int NBYTES_DEFAULT = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_t;

  // Width of an index that addresses n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_result_collector.sv
// Downstream stage of the 8-bit carry-lookahead adder.
// A wide addition is fed LSB byte first: each accepted byte's carry-out is
// registered and returned as the adder's carry-in for the next byte. Once
// NBYTES bytes are held, they are streamed out LSB first with valid/ready,
// together with the carry-out of the most significant byte.
// Writes and reads never overlap in time, so a plain register array is
// enough for the buffer.
module cla_result_collector
  import cla_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sum_in,
  input  logic         cout_in,
  input  logic         sum_valid,
  output logic         sum_ready,
  output logic         cin_out,
  input  logic         abort,
  output logic [W-1:0] res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         res_last,
  output logic         final_cout
);

  localparam int            IW       = idx_width(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  state_t        state_reg, state_next;
  logic [IW-1:0] wr_idx_reg, wr_idx_next;
  logic [IW-1:0] rd_idx_reg, rd_idx_next;
  logic          carry_reg, carry_next;
  logic          final_cout_reg, final_cout_next;

  logic [W-1:0]  data_buf [NBYTES];
  logic          accept;

  // A byte is stored only while collecting; abort drops a coincident byte.
  assign accept = (state_reg == COLLECT) && sum_valid && !abort;

  // Control state, indices and carries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= COLLECT;
      wr_idx_reg     <= '0;
      rd_idx_reg     <= '0;
      carry_reg      <= 1'b0;
      final_cout_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_idx_reg     <= wr_idx_next;
      rd_idx_reg     <= rd_idx_next;
      carry_reg      <= carry_next;
      final_cout_reg <= final_cout_next;
    end
  end

  // Next-state logic: abort wins over any handshake in either state.
  always_comb begin
    state_next      = state_reg;
    wr_idx_next     = wr_idx_reg;
    rd_idx_next     = rd_idx_reg;
    carry_next      = carry_reg;
    final_cout_next = final_cout_reg;

    if (abort) begin
      state_next      = COLLECT;
      wr_idx_next     = '0;
      rd_idx_next     = '0;
      carry_next      = 1'b0;
      final_cout_next = 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (sum_valid) begin
            carry_next = cout_in;
            // The first byte of a new operation retires the previous flag.
            if (wr_idx_reg == '0) begin
              final_cout_next = 1'b0;
            end
            if (wr_idx_reg == LAST_IDX) begin
              final_cout_next = cout_in;
              carry_next      = 1'b0;
              wr_idx_next     = '0;
              rd_idx_next     = '0;
              state_next      = DRAIN;
            end else begin
              wr_idx_next = wr_idx_reg + IDX_ONE;
            end
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (rd_idx_reg == LAST_IDX) begin
              rd_idx_next = '0;
              state_next  = COLLECT;
            end else begin
              rd_idx_next = rd_idx_reg + IDX_ONE;
            end
          end
        end
        default: begin
          state_next = COLLECT;
        end
      endcase
    end
  end

  // Result byte storage; contents need no reset since nothing is emitted
  // until a full operation has been written.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_buf[wr_idx_reg] <= sum_in;
    end
  end

  // Outputs decode from state and registers only, so there is no
  // combinational path from sum_valid or res_ready.
  assign sum_ready  = (state_reg == COLLECT);
  assign cin_out    = carry_reg;
  assign res_valid  = (state_reg == DRAIN);
  assign res_last   = (state_reg == DRAIN) && (rd_idx_reg == LAST_IDX);
  assign res_data   = (state_reg == DRAIN) ? data_buf[rd_idx_reg] : '0;
  assign final_cout = final_cout_reg;

endmodule

// File: tb/tb_cla_result_collector.sv
// Bench for cla_result_collector with NBYTES=4. The adder is modelled here:
// each byte sum is a+b+cin_out. Expected result bytes come from a plain
// 33-bit addition of the two operands and are queued for a monitor that
// checks every output handshake.
module tb_cla_result_collector;

  localparam int NB = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] sum_in;
  logic       cout_in;
  logic       sum_valid;
  logic       sum_ready;
  logic       cin_out;
  logic       abort;
  logic [7:0] res_data;
  logic       res_valid;
  logic       res_ready;
  logic       res_last;
  logic       final_cout;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       fc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   rr_random = 0;

  cla_result_collector #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sum_in     (sum_in),
    .cout_in    (cout_in),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .cin_out    (cin_out),
    .abort      (abort),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_last   (res_last),
    .final_cout (final_cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake must match the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", res_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_last", res_last, e.last);
          check("final_cout_drain", final_cout, e.fc);
          $display("out byte 0x%02h last=%0b final_cout=%0b", res_data, res_last, final_cout);
        end
      end
    end
  end

  // Optional random downstream backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) res_ready = 1'($urandom_range(0, 1));
    end
  end

  // Feed k bytes of a+b through the modelled adder (k<NB leaves it partial).
  task automatic send_op(input logic [31:0] a, input logic [31:0] b,
                         input int k, input bit gaps);
    logic [32:0] full, m, s;
    logic [8:0]  bs;
    int          waitc, n;
    full = {1'b0, a} + {1'b0, b};
    for (int i = 0; i < k; i++) begin
      if (gaps) begin
        sum_valid = 1'b0;
        n = $urandom_range(0, 2);
        repeat (n) begin @(posedge clk); #1; end
      end
      waitc = 0;
      while (!sum_ready && waitc < 300) begin
        sum_valid = 1'b0;
        @(posedge clk); #1;
        waitc++;
      end
      if (!sum_ready) begin
        check("sum_ready_timeout", sum_ready, 1'b1);
        return;
      end
      m  = (33'd1 << (8 * i)) - 33'd1;
      s  = ({1'b0, a} & m) + ({1'b0, b} & m);
      check("cin_out", cin_out, s[8 * i]);
      bs = {1'b0, a[8*i +: 8]} + {1'b0, b[8*i +: 8]} + {8'd0, cin_out};
      sum_in    = bs[7:0];
      cout_in   = bs[8];
      sum_valid = 1'b1;
      if (i == NB - 1) begin
        check("res_valid_early", res_valid, 1'b0);
        for (int j = 0; j < NB; j++) begin
          exp_q.push_back('{data: full[8*j +: 8], last: (j == NB - 1), fc: full[32]});
        end
      end
      @(posedge clk); #1;
    end
    sum_valid = 1'b0;
    if (k == NB) begin
      check("res_valid_latency", res_valid, 1'b1);
      $display("op a=0x%08h b=0x%08h expect 0x%09h", a, b, full);
    end
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (!(exp_q.size() == 0 && !res_valid) && c < 400) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_done", (exp_q.size() == 0 && !res_valid), 1'b1);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; sum_in = '0; cout_in = 1'b0; sum_valid = 1'b0;
    abort = 1'b0; res_ready = 1'b0;
    #1;
    check("rst_sum_ready", sum_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_cin_out", cin_out, 1'b0);
    check("rst_final_cout", final_cout, 1'b0);
    check("rst_res_last", res_last, 1'b0);
    check("rst_res_data", res_data, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed carry patterns with continuous ready.
    res_ready = 1'b1;
    send_op(32'h000000FF, 32'h00000001, NB, 1'b0);
    wait_drain();
    check("final_cout_hold0", final_cout, 1'b0);
    send_op(32'hFFFFFFFF, 32'h00000001, NB, 1'b0);
    wait_drain();
    check("final_cout_hold1", final_cout, 1'b1);

    // Backpressure: output held stable for 5 cycles, then toggled ready.
    res_ready = 1'b0;
    send_op(32'h89ABCDEF, 32'h76543210, NB, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", res_valid, 1'b1);
      check("bp_data", res_data, exp_q[0].data);
      check("bp_last", res_last, exp_q[0].last);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 12; i++) begin
      res_ready = ~res_ready;
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    wait_drain();

    // sum_valid held during DRAIN must be ignored.
    res_ready = 1'b0;
    send_op(32'hFFFFFFFF, 32'hFFFFFFFF, NB, 1'b0);
    sum_valid = 1'b1; sum_in = 8'hAA; cout_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_sum_ready", sum_ready, 1'b0);
      @(posedge clk); #1;
    end
    sum_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain();
    check("final_cout_before_abort", final_cout, 1'b1);

    // Abort after two bytes; the coincident byte is dropped.
    send_op(32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0);
    abort = 1'b1; sum_valid = 1'b1; sum_in = 8'h55; cout_in = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; sum_valid = 1'b0;
    check("abort_sum_ready", sum_ready, 1'b1);
    check("abort_cin_out", cin_out, 1'b0);
    check("abort_final_cout", final_cout, 1'b0);
    check("abort_res_valid", res_valid, 1'b0);
    send_op(32'h12345678, 32'h9ABCDEF0, NB, 1'b0);
    wait_drain();

    // Asynchronous reset after two drained bytes.
    res_ready = 1'b0;
    send_op(32'hFFFFFFFF, 32'h00000001, NB, 1'b0);
    res_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    res_ready = 1'b0;
    check("pre_reset_valid", res_valid, 1'b1);
    check("pre_reset_final_cout", final_cout, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_res_valid", res_valid, 1'b0);
    check("async_rst_final_cout", final_cout, 1'b0);
    check("async_rst_res_last", res_last, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_reset_sum_ready", sum_ready, 1'b1);
    res_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("post_reset_no_output", res_valid, 1'b0);
    check("post_reset_cin_out", cin_out, 1'b0);

    // Random operands, input gaps and random backpressure.
    rr_random = 1'b1;
    for (int t = 0; t < 20; t++) begin
      ra = $urandom;
      rb = $urandom;
      if (t % 5 == 0) rb = ~ra;
      send_op(ra, rb, NB, 1'b1);
    end
    wait_drain();
    rr_random = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
